uart_boot_ctrl: RTL and testbench
=================================

# uart_boot_ctrl

Boot-load sequencer between the UART receive path and instruction memory. Consumes the received byte stream, packs bytes into 32-bit words, and writes them to consecutive word addresses with a valid/ready handshake. Holds the CPU in reset until a terminator word ends the load, and flags overflow, capacity and timeout errors.

## Interface
- ADDR_W, 10, word-address width; capacity 2^ADDR_W words
- END_WORD, 32'h1111_1111, terminator word; not written to memory
- TIMEOUT_CYCLES, 1_000_000, idle cycles in LOAD before error (BOOT_TIMEOUT_EN only)
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- reload_req  in  1  one-cycle request to restart loading
- mem_we  out  1  write request, held until accepted
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- mem_addr  out  ADDR_W  word address of current write
- mem_wdata  out  32  write data
- cpu_reset_n  out  1  low holds CPU in reset
- load_done  out  1  load completed successfully
- load_error  out  1  load aborted
- word_count  out  ADDR_W+1  words written since last (re)start

## Operation
- Packing: shift left, first byte ends in [31:24]: pack = {pack[23:0], rx_byte}; 2-bit byte counter wraps 3->0.
- States: IDLE, LOAD, DRAIN, DONE, ERROR.
- IDLE: cpu_reset_n=0. rx_valid -> byte packed, go LOAD.
- LOAD: on 4th byte of a word:
  - word == END_WORD -> DRAIN;
  - else write slot still pending -> ERROR (overflow);
  - else word_count == 2^ADDR_W -> ERROR (capacity);
  - else load slot: mem_wdata=word, mem_we=1.
- Write accept (mem_we && mem_ready): mem_we=0, mem_addr+1 (wraps only at capacity, error reached first), word_count+1.
- DRAIN: wait until mem_we==0 -> DONE.
- DONE: cpu_reset_n=1, load_done=1; rx_valid ignored.
- ERROR: load_error=1, cpu_reset_n=0, mem_we forced 0; rx_valid ignored.
- reload_req in any state: -> IDLE; clear pack, byte counter, mem_we, mem_addr, word_count, load_done, load_error; cpu_reset_n=0.
- reload_req with rx_valid same cycle: reload wins, byte dropped.
- reload_req with write accept same cycle: reload wins, count not incremented.

## Timing
- Reset: mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset_n 0, load_done 0, load_error 0, word_count 0, state IDLE; partial word discarded.
- All outputs registered.
- mem_we rises the cycle after the rx_valid carrying byte 4.
- mem_addr/word_count update the cycle after acceptance.
- Min byte spacing 1 cycle; one write slot, so 4 cycles' slack before overflow.
- Terminator to load_done: 1 cycle if no write pending, else 1 cycle after the final accept.
- mem_wdata stable while mem_we=1.

## Configuration
- BOOT_TIMEOUT_EN defined: counter cleared on every rx_valid and on entry to LOAD; increments each LOAD cycle; reaching TIMEOUT_CYCLES -> ERROR. DRAIN not timed.
- Undefined: no counter, no timeout; LOAD waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package boot_pkg: state enum boot_state_t {IDLE, LOAD, DRAIN, DONE, ERROR}, BOOT_WORD_W=32, default END_WORD.
- One sub-module: boot_word_packer (shift register, byte counter, word_valid strobe, clear input).

## Test plan
- Bytes 01 02 03 04, 11 11 11 11, mem_ready=1 -> one write addr 0 data 32'h01020304; load_done=1, cpu_reset_n=1, word_count=1.
- 3 words with mem_ready low 2 cycles per write -> addrs 0,1,2 in order; mem_wdata held while stalled; word_count=3.
- mem_ready=0; two full words back-to-back -> load_error=1 on 2nd word's 4th byte, mem_we=0.
- ADDR_W=2, 5 data words -> 4 writes, 5th completed word -> load_error=1.
- Error state, then reload_req, then a valid load -> fresh load from addr 0, word_count restarts.
- BOOT_TIMEOUT_EN, TIMEOUT_CYCLES=100: 2 bytes then silence -> load_error at cycle 100 after last byte; undefined -> no error.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot-load sequencer.
package boot_pkg;

    // Width of one instruction-memory word.
    localparam int BOOT_WORD_W = 32;

    // Default terminator word that ends a load; never written to memory.
    localparam logic [BOOT_WORD_W-1:0] BOOT_END_WORD = 32'h1111_1111;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream into 32-bit words, first byte in [31:24].
// The completed word and its strobe are presented combinationally together
// with the fourth byte, so the controller can act on the same clock edge.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    output logic [BOOT_WORD_W-1:0] word,
    output logic                   word_valid
);

    // Only the three most recent bytes need storage; the fourth is byte_in.
    logic [23:0] pack;
    logic [1:0]  byte_cnt;

    assign word       = {pack, byte_in};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

    // Shift in accepted bytes; clear discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            pack     <= word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: packs UART bytes into words, writes them to
// consecutive instruction-memory addresses over a one-slot valid/ready port,
// and releases the CPU from reset once the terminator word arrives.
// Optional idle timeout in LOAD is enabled by defining BOOT_TIMEOUT_EN.
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int                     ADDR_W         = 10,
    parameter logic [BOOT_WORD_W-1:0] END_WORD       = BOOT_END_WORD,
    parameter int                     TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   reload_req,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [BOOT_WORD_W-1:0] mem_wdata,
    output logic                   cpu_reset_n,
    output logic                   load_done,
    output logic                   load_error,
    output logic [ADDR_W:0]        word_count
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    boot_state_t            state;
    boot_state_t            next_state;
    logic [BOOT_WORD_W-1:0] word;
    logic                   word_valid;
    logic                   byte_take;
    logic                   accept;
    logic                   load_slot;
    logic                   timeout;
    logic                   done_d;
    logic                   error_d;

    // Bytes are only consumed while collecting; a simultaneous reload drops them.
    assign byte_take = rx_valid && !reload_req && (state == IDLE || state == LOAD);
    assign accept    = mem_we && mem_ready;
    // The single write slot must already be empty; a same-cycle accept does not free it.
    assign load_slot = (state == LOAD) && word_valid && (word != END_WORD) &&
                       !mem_we && (word_count != CAPACITY) && !reload_req;

    boot_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (reload_req),
        .byte_valid (byte_take),
        .byte_in    (rx_byte),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef BOOT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] idle_cnt;

    // Count consecutive LOAD cycles without a byte; zero outside LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (reload_req || rx_valid || state != LOAD) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = (state == LOAD) && !rx_valid &&
                     (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; reload overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (byte_take) next_state = LOAD;
            end
            LOAD: begin
                if (word_valid) begin
                    if (word == END_WORD) begin
                        // Skip DRAIN when nothing is left waiting after this edge.
                        next_state = (mem_we && !mem_ready) ? DRAIN : DONE;
                    end else if (mem_we) begin
                        next_state = ERROR;
                    end else if (word_count == CAPACITY) begin
                        next_state = ERROR;
                    end
                end else if (timeout) begin
                    next_state = ERROR;
                end
            end
            DRAIN: begin
                if (!mem_we || mem_ready) next_state = DONE;
            end
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase
        if (reload_req) next_state = IDLE;
    end

    // Status values derived from the state being entered, so they register in step.
    always_comb begin
        done_d  = (next_state == DONE);
        error_d = (next_state == ERROR);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset_n <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            cpu_reset_n <= done_d;
            load_done   <= done_d;
            load_error  <= error_d;
        end
    end

    // Write slot, address and word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else if (reload_req) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
        end else begin
            if (accept) begin
                mem_we     <= 1'b0;
                mem_addr   <= mem_addr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (load_slot) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
            end
            if (next_state == ERROR) mem_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Scoreboard bench for uart_boot_ctrl (ADDR_W=2, TIMEOUT_CYCLES=100).
module tb_uart_boot_ctrl;

    localparam int ADDR_W = 2;
    localparam int TMO    = 100;
    localparam logic [31:0] ENDW = 32'h1111_1111;

    logic              clk;
    logic              reset_n;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              reload_req;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset_n;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   word_count;

    int errors = 0;
    int checks = 0;
    int stall_cycles = 0;
    int wait_cnt = 0;
    logic force_low = 1'b0;
    logic [63:0] exp_q[$];

    uart_boot_ctrl #(
        .ADDR_W         (ADDR_W),
        .END_WORD       (ENDW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .reload_req  (reload_req),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_error  (load_error),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic reload();
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({32'(addr), data});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory responder: hold ready low for stall_cycles after each request.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (force_low) begin
                mem_ready = 1'b0;
            end else if (mem_we) begin
                if (wait_cnt >= stall_cycles) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: every presented write must match the queue head (held data too).
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            if (exp_q.size() == 0) begin
                if (mem_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h with no write expected",
                             mem_addr, mem_wdata);
                end
            end else begin
                chk(mem_ready ? "write" : "held_write", {32'(mem_addr), mem_wdata}, exp_q[0]);
                if (mem_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        reload_req = 1'b0;
        repeat (3) tick();
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_load_error", 64'(load_error), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single word then terminator.
        stall_cycles = 0;
        expect_write(0, 32'h0102_0304);
        send_word(32'h0102_0304);
        chk("we_after_byte4", 64'(mem_we), 64'd1);
        send_word(ENDW);
        chk("t1_load_done", 64'(load_done), 64'd1);
        chk("t1_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
        chk("t1_word_count", 64'(word_count), 64'd1);
        chk("t1_load_error", 64'(load_error), 64'd0);
        chk("t1_mem_addr", 64'(mem_addr), 64'd1);
        send_word(32'h2233_4455);
        tick();
        chk("done_ignores_rx", 64'(word_count), 64'd1);
        chk("done_no_we", 64'(mem_we), 64'd0);

        // Terminator while a write is still waiting: DRAIN until accepted.
        reload();
        chk("reload_done", 64'(load_done), 64'd0);
        chk("reload_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        chk("reload_count", 64'(word_count), 64'd0);
        stall_cycles = 6;
        expect_write(0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        send_word(ENDW);
        chk("drain_done_0a", 64'(load_done), 64'd0);
        repeat (2) tick();
        chk("drain_done_0b", 64'(load_done), 64'd0);
        tick();
        chk("drain_done_1", 64'(load_done), 64'd1);
        chk("drain_count", 64'(word_count), 64'd1);

        // Three words with a 2-cycle stall on each write.
        reload();
        stall_cycles = 2;
        expect_write(0, 32'hA1A2_A3A4);
        expect_write(1, 32'hB1B2_B3B4);
        expect_write(2, 32'hC1C2_C3C4);
        send_word(32'hA1A2_A3A4);
        send_word(32'hB1B2_B3B4);
        send_word(32'hC1C2_C3C4);
        send_word(ENDW);
        wait_drain();
        chk("t2_load_done", 64'(load_done), 64'd1);
        chk("t2_word_count", 64'(word_count), 64'd3);
        chk("t2_mem_addr", 64'(mem_addr), 64'd3);

        // Overflow: memory never ready, second word lands on a full slot.
        reload();
        force_low = 1'b1;
        send_word(32'hAABB_CCDD);
        chk("ovf_first_we", 64'(mem_we), 64'd1);
        send_word(32'h5566_7788);
        chk("ovf_load_error", 64'(load_error), 64'd1);
        chk("ovf_mem_we", 64'(mem_we), 64'd0);
        chk("ovf_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
        chk("ovf_word_count", 64'(word_count), 64'd0);
        force_low = 1'b0;
        send_word(32'h0000_0001);
        tick();
        chk("err_ignores_rx", 64'(mem_we), 64'd0);

        // Capacity: 4 words fit with ADDR_W=2, the fifth is an error.
        reload();
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) expect_write(i, 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i));
        chk("cap_load_error", 64'(load_error), 64'd1);
        chk("cap_word_count", 64'(word_count), 64'd4);
        chk("cap_mem_we", 64'(mem_we), 64'd0);
        chk("cap_load_done", 64'(load_done), 64'd0);

        // Recovery from error with a fresh load.
        reload();
        chk("rec_load_error", 64'(load_error), 64'd0);
        chk("rec_mem_addr", 64'(mem_addr), 64'd0);
        chk("rec_word_count", 64'(word_count), 64'd0);
        expect_write(0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        send_word(ENDW);
        chk("rec_load_done", 64'(load_done), 64'd1);
        chk("rec_word_count1", 64'(word_count), 64'd1);

        // Idle timeout after a partial word.
        reload();
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (99) tick();
        chk("tmo_early", 64'(load_error), 64'd0);
        tick();
`ifdef BOOT_TIMEOUT_EN
        chk("tmo_error", 64'(load_error), 64'd1);
`else
        chk("tmo_disabled", 64'(load_error), 64'd0);
        repeat (200) tick();
        chk("tmo_disabled_long", 64'(load_error), 64'd0);
`endif

        // Reload and byte in the same cycle: the byte is dropped.
        reload_req = 1'b1;
        rx_valid   = 1'b1;
        rx_byte    = 8'hEE;
        tick();
        reload_req = 1'b0;
        rx_valid   = 1'b0;
        chk("rr_word_count", 64'(word_count), 64'd0);
        expect_write(0, 32'h0A0B_0C0D);
        send_word(32'h0A0B_0C0D);
        send_word(ENDW);
        chk("rr_load_done", 64'(load_done), 64'd1);

        // Reload in the same cycle as a write accept: count stays cleared.
        reload();
        stall_cycles = 1;
        expect_write(0, 32'h7777_8888);
        send_word(32'h7777_8888);
        tick();
        reload();
        chk("ra_word_count", 64'(word_count), 64'd0);
        chk("ra_mem_addr", 64'(mem_addr), 64'd0);
        chk("ra_mem_we", 64'(mem_we), 64'd0);

        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
